fp_result_queue: RTL and testbench

Downstream stage of the FP square-root wrapper. It captures every result, tag and status word the non-stallable sqrt pipeline produces into a small FIFO, and presents them to the APU interconnect writeback with a valid/ready handshake. The sqrt unit cannot be back-pressured, so the block also keeps a credit counter. The credit counter throttles the dispatcher so results can never overflow the queue.

---
 rtl/fp_result_queue_pkg.sv | 16 +
 rtl/fp_result_fifo.sv | 73 +++++++
 rtl/fp_result_queue.sv | 98 +++++++++
 tb/tb_fp_result_queue.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_result_queue_pkg.sv
// Shared types and constants for the FP sqrt result queue.
package fp_result_queue_pkg;

    localparam int unsigned FP_WIDTH        = 32;
    localparam int unsigned WAPUTAG         = 4;
    localparam int unsigned NUSFLAGS_SQRT   = 5;
    localparam int unsigned C_FP_RESQ_DEPTH = 4;

    // One queued sqrt result as it travels toward writeback.
    typedef struct packed {
        logic [FP_WIDTH-1:0]      res;
        logic [WAPUTAG-1:0]       tag;
        logic [NUSFLAGS_SQRT-1:0] status;
    } fp_result_t;

endpackage

// File: rtl/fp_result_fifo.sv
// Generic registered-output storage FIFO (no fall-through).
// A write that coincides with a read is accepted even when full, because
// the read frees the slot that the write pointer is about to reuse.
module fp_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_en, pop_en;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_FULL);
    assign count_o = count_q;

    assign pop_en  = pop_i && !empty_o;
    assign push_en = push_i && (!full_o || pop_en);

    // Head is driven only while valid so the outputs read zero when empty.
    assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Next-state for pointers (power-of-two depth wraps naturally) and count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/fp_result_queue.sv
// Result queue behind the non-stallable sqrt pipe: captures every result,
// hands it to writeback over valid/ready, and meters issue with credits so
// the pipe can never produce more results than the queue can hold.
module fp_result_queue
    import fp_result_queue_pkg::*;
#(
    parameter int unsigned DEPTH      = C_FP_RESQ_DEPTH,
    parameter int unsigned DATA_WIDTH = FP_WIDTH,
    parameter int unsigned TAG_WIDTH  = WAPUTAG,
    parameter int unsigned STAT_WIDTH = NUSFLAGS_SQRT
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         issue_valid_i,
    output logic                         issue_ready_o,
    input  logic                         unit_valid_i,
    input  logic [DATA_WIDTH-1:0]        unit_res_i,
    input  logic [TAG_WIDTH-1:0]         unit_tag_i,
    input  logic [STAT_WIDTH-1:0]        unit_status_i,
    output logic                         res_valid_o,
    input  logic                         res_ready_i,
    output logic [DATA_WIDTH-1:0]        res_data_o,
    output logic [TAG_WIDTH-1:0]         res_tag_o,
    output logic [STAT_WIDTH-1:0]        res_status_o,
    output logic [$clog2(DEPTH+1)-1:0]   credits_o,
    output logic                         empty_o,
    output logic                         overflow_o
);

    localparam int unsigned W  = DATA_WIDTH + TAG_WIDTH + STAT_WIDTH;
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] CRED_ONE = CW'(1);
    localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);

    logic [CW-1:0] credits_q, credits_d;
    logic          overflow_q, overflow_d;
    logic [W-1:0]  head;
    logic          fifo_empty, fifo_full;
    logic [CW-1:0] fifo_count;
    logic          issue_acc, pop;

    assign issue_ready_o = (credits_q != '0);
    assign issue_acc     = issue_valid_i && issue_ready_o;
    assign res_valid_o   = !fifo_empty;
    assign empty_o       = fifo_empty;
    assign pop           = res_valid_o && res_ready_i;
    assign credits_o     = credits_q;
    assign overflow_o    = overflow_q;

    assign {res_data_o, res_tag_o, res_status_o} = head;

    fp_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (unit_valid_i),
        .data_i  ({unit_res_i, unit_tag_i, unit_status_i}),
        .pop_i   (pop),
        .data_o  (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    // Credit update; saturating on both ends so a protocol slip cannot wrap it.
    always_comb begin
        credits_d = credits_q;
        if (issue_acc && !pop) begin
            credits_d = credits_q - CRED_ONE;
        end else if (pop && !issue_acc && (credits_q != CRED_MAX)) begin
            credits_d = credits_q + CRED_ONE;
        end
    end

    // Sticky overflow: a result arrived with no room and no pop to make room.
    always_comb begin
        overflow_d = overflow_q;
        if (unit_valid_i && fifo_full && !pop) overflow_d = 1'b1;
    end

    // Credit and overflow registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credits_q  <= CRED_MAX;
            overflow_q <= 1'b0;
        end else begin
            credits_q  <= credits_d;
            overflow_q <= overflow_d;
        end
    end

    // Occupancy is exposed by the storage block but only full/empty matter here.
    logic unused_count;
    assign unused_count = ^fifo_count;

endmodule

// File: tb/tb_fp_result_queue.sv
// Directed bench for fp_result_queue.
module tb_fp_result_queue;
    import fp_result_queue_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic        unit_valid_i;
    logic [31:0] unit_res_i;
    logic [3:0]  unit_tag_i;
    logic [4:0]  unit_status_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [31:0] res_data_o;
    logic [3:0]  res_tag_o;
    logic [4:0]  res_status_o;
    logic [2:0]  credits_o;
    logic        empty_o;
    logic        overflow_o;

    int n_cmp = 0;
    int n_bad = 0;

    fp_result_queue dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .issue_valid_i (issue_valid_i),
        .issue_ready_o (issue_ready_o),
        .unit_valid_i  (unit_valid_i),
        .unit_res_i    (unit_res_i),
        .unit_tag_i    (unit_tag_i),
        .unit_status_i (unit_status_i),
        .res_valid_o   (res_valid_o),
        .res_ready_i   (res_ready_i),
        .res_data_o    (res_data_o),
        .res_tag_o     (res_tag_o),
        .res_status_o  (res_status_o),
        .credits_o     (credits_o),
        .empty_o       (empty_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Advance one clock; inputs set before the call apply to this edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [31:0] r, input logic [3:0] t, input logic [4:0] s);
        unit_valid_i  = 1'b1;
        unit_res_i    = r;
        unit_tag_i    = t;
        unit_status_i = s;
    endtask

    task automatic idle_unit();
        unit_valid_i  = 1'b0;
        unit_res_i    = '0;
        unit_tag_i    = '0;
        unit_status_i = '0;
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_credits"},  64'(credits_o),     64'd4);
        check({pfx, "_iss_rdy"},  64'(issue_ready_o), 64'd1);
        check({pfx, "_valid"},    64'(res_valid_o),   64'd0);
        check({pfx, "_empty"},    64'(empty_o),       64'd1);
        check({pfx, "_ovf"},      64'(overflow_o),    64'd0);
        check({pfx, "_data"},     64'(res_data_o),    64'd0);
        check({pfx, "_tag"},      64'(res_tag_o),     64'd0);
        check({pfx, "_status"},   64'(res_status_o),  64'd0);
    endtask

    initial begin
        rst_ni        = 1'b0;
        issue_valid_i = 1'b0;
        res_ready_i   = 1'b0;
        idle_unit();
        tick(); tick();
        rst_ni = 1'b1;
        tick();
        check_reset_state("reset");

        // Single op: issue, result two cycles later, writeback ready.
        issue_valid_i = 1'b1;
        tick();
        issue_valid_i = 1'b0;
        check("single_cred_c1", 64'(credits_o), 64'd3);
        tick();
        check("single_cred_c2", 64'(credits_o), 64'd3);
        push(32'h3FC0_0000, 4'd5, 5'h01);
        res_ready_i = 1'b1;
        tick();
        idle_unit();
        check("single_valid", 64'(res_valid_o), 64'd1);
        check("single_data",  64'(res_data_o),  64'h3FC0_0000);
        check("single_tag",   64'(res_tag_o),   64'd5);
        check("single_stat",  64'(res_status_o), 64'h01);
        check("single_cred_c3", 64'(credits_o), 64'd3);
        tick();
        check("single_cred_c4", 64'(credits_o), 64'd4);
        check("single_empty",   64'(empty_o),   64'd1);
        res_ready_i = 1'b0;

        // Back-pressure and ordering.
        issue_valid_i = 1'b1;
        tick(); tick(); tick();
        issue_valid_i = 1'b0;
        check("bp_cred", 64'(credits_o), 64'd1);
        for (int i = 1; i <= 3; i++) begin
            push(32'h4000_0000 + 32'(i), 4'(i), 5'(i));
            tick();
        end
        idle_unit();
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_tag",  64'(res_tag_o),  64'd1);
            check("bp_hold_data", 64'(res_data_o), 64'h4000_0001);
            tick();
        end
        res_ready_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            check("bp_ord_valid", 64'(res_valid_o), 64'd1);
            check("bp_ord_tag",   64'(res_tag_o),   64'(i));
            tick();
        end
        check("bp_drained", 64'(res_valid_o), 64'd0);
        check("bp_cred_back", 64'(credits_o), 64'd4);
        res_ready_i = 1'b0;

        // Credit exhaustion.
        issue_valid_i = 1'b1;
        tick(); tick(); tick(); tick();
        issue_valid_i = 1'b0;
        check("exh_cred0", 64'(credits_o),     64'd0);
        check("exh_rdy0",  64'(issue_ready_o), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            push(32'h5000_0000 + 32'(i), 4'(i), 5'h00);
            tick();
        end
        idle_unit();
        issue_valid_i = 1'b1;
        tick();
        issue_valid_i = 1'b0;
        check("exh_ignored", 64'(credits_o), 64'd0);
        check("exh_ovf",     64'(overflow_o), 64'd0);
        check("exh_head",    64'(res_tag_o),  64'd1);
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        check("exh_cred1",  64'(credits_o),     64'd1);
        check("exh_rdy1",   64'(issue_ready_o), 64'd1);
        check("exh_head2",  64'(res_tag_o),     64'd2);

        // Refill to full (tags 2,3,4,5), then push and pop together.
        issue_valid_i = 1'b1;
        tick();
        issue_valid_i = 1'b0;
        push(32'h5000_0005, 4'd5, 5'h00);
        tick();
        idle_unit();
        check("full_rdy0", 64'(issue_ready_o), 64'd0);
        push(32'h5000_0006, 4'd6, 5'h00);
        res_ready_i = 1'b1;
        tick();
        idle_unit();
        res_ready_i = 1'b0;
        check("full_pp_ovf",  64'(overflow_o), 64'd0);
        check("full_pp_head", 64'(res_tag_o),  64'd3);
        check("full_pp_cred", 64'(credits_o),  64'd1);
        res_ready_i = 1'b1;
        for (int i = 3; i <= 6; i++) begin
            check("full_pp_tag",  64'(res_tag_o),  64'(i));
            check("full_pp_data", 64'(res_data_o), 64'h5000_0000 + 64'(i));
            tick();
        end
        res_ready_i = 1'b0;
        check("full_pp_empty", 64'(empty_o),   64'd1);
        check("cred_sat",      64'(credits_o), 64'd4);

        // Overflow: push a fifth result with no pop.
        issue_valid_i = 1'b1;
        tick(); tick(); tick(); tick();
        issue_valid_i = 1'b0;
        for (int i = 7; i <= 10; i++) begin
            push(32'h6000_0000 + 32'(i), 4'(i), 5'h02);
            tick();
        end
        check("ovf_pre", 64'(overflow_o), 64'd0);
        push(32'h6000_000B, 4'd11, 5'h1F);
        tick();
        idle_unit();
        check("ovf_set",  64'(overflow_o), 64'd1);
        check("ovf_head", 64'(res_tag_o),  64'd7);
        res_ready_i = 1'b1;
        for (int i = 7; i <= 10; i++) begin
            check("ovf_drop_tag", 64'(res_tag_o), 64'(i));
            tick();
        end
        res_ready_i = 1'b0;
        check("ovf_dropped", 64'(res_valid_o), 64'd0);
        check("ovf_sticky",  64'(overflow_o),  64'd1);

        // Mid-stream asynchronous reset with an entry queued.
        issue_valid_i = 1'b1;
        tick();
        issue_valid_i = 1'b0;
        push(32'h7000_0001, 4'd9, 5'h03);
        tick();
        idle_unit();
        check("pre_rst_valid", 64'(res_valid_o), 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_state("async_rst");
        tick();
        #2;
        rst_ni = 1'b1;
        tick();
        check_reset_state("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
